// File: rtl/stopwatch_ctrl_fsm_if.sv
// Command/status bundle between the push-button front ends, the stopwatch
// controller and the digit-counter / display datapath.
interface stopwatch_ctrl_fsm_if;
  // Commands are single-cycle pulses with no handshake. Every cycle a command is
  // high counts as one event. Status outputs are registered levels, except tick
  // and clear, which are one-cycle pulses.
  logic       start_stop;
  logic       lap_reset;
  logic       run;
  logic       tick;
  logic       freeze;
  logic       clear;
  logic [1:0] state;

  modport master (
    output start_stop, lap_reset,
    input  run, tick, freeze, clear, state
  );

  modport slave (
    input  start_stop, lap_reset,
    output run, tick, freeze, clear, state
  );
endinterface

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch run/lap/clear controller with the tick prescaler that drives the
// digit counters. All outputs are registered.
module stopwatch_ctrl_fsm #(
  parameter int DIV   = 500000,
  parameter int CNT_W = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stopwatch_ctrl_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    LAP     = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic               run_q, run_d;
  logic               freeze_q, freeze_d;
  logic               clear_q, clear_d;
  logic               tick_q;
  logic [CNT_W-1:0]   cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: start_stop wins over lap_reset when both are high.
  always_comb begin
    state_d = state_q;
    if (bus.start_stop) begin
      case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        LAP:     state_d = PAUSED;
        default: state_d = IDLE;
      endcase
    end else if (bus.lap_reset) begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUNNING: state_d = LAP;
        PAUSED:  state_d = IDLE;
        LAP:     state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with state after the same edge.
  always_comb begin
    run_d    = (state_d == RUNNING) || (state_d == LAP);
    freeze_d = (state_d == LAP);
    clear_d  = (state_q == PAUSED) && !bus.start_stop && bus.lap_reset;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      freeze_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      run_q    <= run_d;
      freeze_q <= freeze_d;
      clear_q  <= clear_d;
    end
  end

  // Prescaler follows the pre-transition run value, so a paused partial
  // interval survives until resume; only a clear discards it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clear_d) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (run_q) begin
      if (cnt_q == CNT_W'(DIV - 1)) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign bus.state  = state_q;
  assign bus.run    = run_q;
  assign bus.freeze = freeze_q;
  assign bus.clear  = clear_q;
  assign bus.tick   = tick_q;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Bench for stopwatch_ctrl_fsm: directed scenarios followed by random command
// traffic, all checked every cycle against a transition-table reference model.
module tb_stopwatch_ctrl_fsm;
  localparam int DIV   = 4;
  localparam int CNT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  stopwatch_ctrl_fsm_if bus ();

  stopwatch_ctrl_fsm #(.DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 running, 2 paused, 3 lap. Transitions as lookup tables.
  int ss_next [4] = '{1, 2, 1, 2};
  int lr_next [4] = '{0, 3, 0, 1};
  int m_mode;
  int m_cnt;
  int m_tick;
  int m_clear;
  int tick_seen;

  int n_cmp;
  int n_err;

  function automatic int mode_runs(int mode);
    return (mode == 1 || mode == 3) ? 1 : 0;
  endfunction

  task automatic model_edge(input int ss, input int lr, input int rn);
    int nm;
    if (rn == 0) begin
      m_mode = 0; m_cnt = 0; m_tick = 0; m_clear = 0;
      return;
    end
    if (mode_runs(m_mode) == 1) begin
      m_tick = (m_cnt == DIV - 1) ? 1 : 0;
      m_cnt  = (m_cnt + 1) % DIV;
    end else begin
      m_tick = 0;
    end
    m_clear = 0;
    nm = m_mode;
    if (ss != 0)      nm = ss_next[m_mode];
    else if (lr != 0) nm = lr_next[m_mode];
    if (m_mode == 2 && nm == 0) begin
      m_clear = 1;
      m_cnt   = 0;
      m_tick  = 0;
    end
    m_mode = nm;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",  32'(bus.state),  32'(m_mode));
    check("run",    32'(bus.run),    32'(mode_runs(m_mode)));
    check("freeze", 32'(bus.freeze), 32'(m_mode == 3 ? 1 : 0));
    check("clear",  32'(bus.clear),  32'(m_clear));
    check("tick",   32'(bus.tick),   32'(m_tick));
  endtask

  // ---------------- driver ----------------
  // Inputs change just after the falling edge; outputs are checked on the next
  // falling edge after the model has taken the rising edge.
  task automatic step(input int ss, input int lr, input int rn);
    bus.start_stop = ss[0];
    bus.lap_reset  = lr[0];
    rst_n          = rn[0];
    @(posedge clk);
    model_edge(ss, lr, rn);
    @(negedge clk);
    check_all();
    if (bus.tick === 1'b1) tick_seen++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; tick_seen = 0;
    m_mode = 0; m_cnt = 0; m_tick = 0; m_clear = 0;
    bus.start_stop = 1'b0;
    bus.lap_reset  = 1'b0;
    rst_n          = 1'b0;
    @(negedge clk);

    // Reset held two cycles with start_stop high.
    step(1, 0, 0);
    step(1, 0, 0);
    check("reset_state", 32'(bus.state), 32'd0);

    // Start, then ticks every DIV cycles.
    step(1, 0, 1);
    idle_cycles(3);
    check("no_early_tick", 32'(bus.tick), 32'd0);
    step(0, 0, 1);
    check("first_tick", 32'(bus.tick), 32'd1);
    idle_cycles(9);

    // Pause mid-interval, hold, resume.
    step(1, 0, 1);
    idle_cycles(10);
    step(1, 0, 1);
    idle_cycles(6);

    // Lap freeze/unfreeze, then pause from lap.
    step(0, 1, 1);
    check("lap_freeze", 32'(bus.freeze), 32'd1);
    idle_cycles(6);
    step(0, 1, 1);
    check("lap_unfreeze", 32'(bus.freeze), 32'd0);
    step(0, 1, 1);
    step(1, 0, 1);
    check("lap_to_pause", 32'(bus.state), 32'd2);

    // Clear from paused, then lap_reset in idle gives no clear.
    step(0, 1, 1);
    check("clear_pulse", 32'(bus.clear), 32'd1);
    step(0, 0, 1);
    check("clear_one_cycle", 32'(bus.clear), 32'd0);
    step(0, 1, 1);
    idle_cycles(2);

    // Both commands while running: start_stop wins.
    step(1, 0, 1);
    idle_cycles(2);
    step(1, 1, 1);
    check("simul_pause", 32'(bus.state), 32'd2);

    // Reset while in lap.
    step(1, 0, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    check("reset_from_lap", 32'(bus.freeze), 32'd0);

    // Random command traffic.
    for (int i = 0; i < 3000; i++) begin
      int ss, lr, rn;
      ss = ($urandom_range(0, 7) == 0) ? 1 : 0;
      lr = ($urandom_range(0, 7) == 0) ? 1 : 0;
      rn = ($urandom_range(0, 199) == 0) ? 0 : 1;
      step(ss, lr, rn);
    end
    check("ticks_observed", 32'(tick_seen > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
